// File: rtl/decodificador_enderecos.sv
// Physical-to-logical address decoder: recovers (indice, offset) from a 16-bit
// physical address by restoring shift-subtract division by the selected block size.
//
// state     | meaning
// OCIOSO    | idle, waiting for iniciar
// DIVIDINDO | one quotient bit per clock, 16 iterations
// PRONTO    | results registered, valido pulse for one cycle
module decodificador_enderecos #(
   parameter int TAM_BLOCO_INSTR = 500,
   parameter int TAM_BLOCO_DADOS = 100,
   parameter int MAX_INDICE      = 31
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iniciar,
   input  logic        regiao,
   input  logic [15:0] enderecoFisico,
   output logic        ocupado,
   output logic        valido,
   output logic [4:0]  indice,
   output logic [15:0] offset,
   output logic        erro
);

   localparam logic [1:0] OCIOSO    = 2'd0;
   localparam logic [1:0] DIVIDINDO = 2'd1;
   localparam logic [1:0] PRONTO    = 2'd2;

   logic [1:0]  r_estado;
   logic [15:0] r_dividendo;
   logic [16:0] r_divisor;
   logic [16:0] r_resto;
   logic [15:0] r_quociente;
   logic [3:0]  r_contador;
   logic [4:0]  r_indice;
   logic [15:0] r_offset;
   logic        r_erro;

   logic [16:0] w_resto_desloc;
   logic        w_subtrai;
   logic [16:0] w_resto_novo;
   logic [15:0] w_quoc_novo;
   logic        w_estouro;

   always_comb begin
      w_resto_desloc = {r_resto[15:0], r_dividendo[r_contador]};
      w_subtrai      = (w_resto_desloc >= r_divisor);
      w_resto_novo   = w_subtrai ? (w_resto_desloc - r_divisor) : w_resto_desloc;
      w_quoc_novo    = r_quociente;
      w_quoc_novo[r_contador] = w_subtrai;
      w_estouro      = (w_quoc_novo > 16'(MAX_INDICE));
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_estado    <= OCIOSO;
         r_dividendo <= '0;
         r_divisor   <= '0;
         r_resto     <= '0;
         r_quociente <= '0;
         r_contador  <= '0;
         r_indice    <= '0;
         r_offset    <= '0;
         r_erro      <= 1'b0;
      end else begin
         case (r_estado)
            OCIOSO: begin
               if (iniciar) begin
                  r_dividendo <= enderecoFisico;
                  r_divisor   <= regiao ? 17'(TAM_BLOCO_DADOS) : 17'(TAM_BLOCO_INSTR);
                  r_resto     <= '0;
                  r_quociente <= '0;
                  r_contador  <= 4'd15;
                  r_estado    <= DIVIDINDO;
               end
            end
            DIVIDINDO: begin
               r_resto     <= w_resto_novo;
               r_quociente <= w_quoc_novo;
               if (r_contador == 4'd0) begin
                  // Indices beyond the 5-bit field saturate and flag erro.
                  r_offset <= w_resto_novo[15:0];
                  r_erro   <= w_estouro;
                  r_indice <= w_estouro ? 5'(MAX_INDICE) : w_quoc_novo[4:0];
                  r_estado <= PRONTO;
               end else begin
                  r_contador <= r_contador - 4'd1;
               end
            end
            PRONTO:  r_estado <= OCIOSO;
            default: r_estado <= OCIOSO;
         endcase
      end
   end

   assign ocupado = (r_estado == DIVIDINDO);
   assign valido  = (r_estado == PRONTO);
   assign indice  = r_indice;
   assign offset  = r_offset;
   assign erro    = r_erro;

endmodule

// File: tb/tb_decodificador_enderecos.sv
// Directed and round-trip bench for decodificador_enderecos.
module tb_decodificador_enderecos;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        iniciar = 1'b0;
   logic        regiao = 1'b0;
   logic [15:0] enderecoFisico = '0;
   logic        ocupado, valido, erro;
   logic [4:0]  indice;
   logic [15:0] offset;

   int checks = 0;
   int failures = 0;

   decodificador_enderecos dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .regiao(regiao),
      .enderecoFisico(enderecoFisico), .ocupado(ocupado), .valido(valido),
      .indice(indice), .offset(offset), .erro(erro)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        reg_sel;
      logic [15:0] addr;
      int          exp_idx;
      int          exp_off;
      int          exp_err;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Runs one decode; returns latency in edges after the start edge, busy-cycle count,
   // results, and valido one cycle after the pulse. Ends with the DUT back in OCIOSO.
   task automatic run_decode(input logic reg_sel, input logic [15:0] addr,
                             output int lat, output int busy, output int seen,
                             output int idx, output int off, output int err,
                             output int val_after);
      @(negedge clock);
      regiao = reg_sel;
      enderecoFisico = addr;
      iniciar = 1'b1;
      @(posedge clock);
      #1;
      iniciar = 1'b0;
      regiao = ~reg_sel;
      enderecoFisico = ~addr;
      lat = 0;
      busy = 0;
      while (!valido && lat < 40) begin
         if (ocupado) busy++;
         @(posedge clock);
         #1;
         lat++;
      end
      seen = valido;
      idx = indice;
      off = offset;
      err = erro;
      @(posedge clock);
      #1;
      val_after = valido;
   endtask

   int lat, busy, seen, idx, off, err, vafter;
   int pulses, pulse_k, h_idx, h_off, busy18, extra_valid;
   int rt_bad;
   int div, e_idx, e_off;
   logic rsel;

   initial begin
      vecs[0]  = '{1'b0, 16'd1234,  2, 234, 0};
      vecs[1]  = '{1'b1, 16'd299,   2,  99, 0};
      vecs[2]  = '{1'b1, 16'd300,   3,   0, 0};
      vecs[3]  = '{1'b1, 16'd0,     0,   0, 0};
      vecs[4]  = '{1'b1, 16'd65535, 31, 35, 1};
      vecs[5]  = '{1'b0, 16'd16000, 31,  0, 1};
      vecs[6]  = '{1'b0, 16'd499,   0, 499, 0};
      vecs[7]  = '{1'b0, 16'd500,   1,   0, 0};
      vecs[8]  = '{1'b0, 16'd15999, 31, 499, 0};
      vecs[9]  = '{1'b1, 16'd3199,  31,  99, 0};
      vecs[10] = '{1'b1, 16'd3200,  31,   0, 1};
      vecs[11] = '{1'b0, 16'd65535, 31,  35, 1};

      repeat (3) @(posedge clock);
      #1;
      chk("reset_ocupado", ocupado, 0);
      chk("reset_valido", valido, 0);
      chk("reset_indice", indice, 0);
      chk("reset_offset", offset, 0);
      chk("reset_erro", erro, 0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_decode(vecs[i].reg_sel, vecs[i].addr, lat, busy, seen, idx, off, err, vafter);
         chk($sformatf("v%0d_valid_seen", i), seen, 1);
         chk($sformatf("v%0d_latency", i), lat, 16);
         chk($sformatf("v%0d_busy_cycles", i), busy, 16);
         chk($sformatf("v%0d_indice", i), idx, vecs[i].exp_idx);
         chk($sformatf("v%0d_offset", i), off, vecs[i].exp_off);
         chk($sformatf("v%0d_erro", i), err, vecs[i].exp_err);
         chk($sformatf("v%0d_valid_one_cycle", i), vafter, 0);
      end

      // Handshake: re-requests during DIVIDINDO and PRONTO must be dropped.
      @(negedge clock);
      regiao = 1'b0;
      enderecoFisico = 16'd700;
      iniciar = 1'b1;
      @(posedge clock);
      pulses = 0; pulse_k = -1; h_idx = -1; h_off = -1; busy18 = -1;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clock);
         iniciar = (k == 3 || k == 17);
         enderecoFisico = 16'd999;
         @(posedge clock);
         #1;
         if (valido) begin
            pulses++;
            pulse_k = k;
            h_idx = indice;
            h_off = offset;
         end
         if (k == 18) busy18 = ocupado;
      end
      iniciar = 1'b0;
      chk("hs_pulses", pulses, 1);
      chk("hs_pulse_edge", pulse_k, 16);
      chk("hs_indice", h_idx, 1);
      chk("hs_offset", h_off, 200);
      chk("hs_not_queued", busy18, 0);
      run_decode(1'b0, 16'd999, lat, busy, seen, idx, off, err, vafter);
      chk("hs2_valid_seen", seen, 1);
      chk("hs2_indice", idx, 1);
      chk("hs2_offset", off, 499);
      chk("hs2_erro", err, 0);

      // Reset in the middle of a decode.
      @(negedge clock);
      regiao = 1'b0;
      enderecoFisico = 16'd1234;
      iniciar = 1'b1;
      @(posedge clock);
      @(negedge clock);
      iniciar = 1'b0;
      repeat (7) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      chk("rst_ocupado", ocupado, 0);
      chk("rst_valido", valido, 0);
      chk("rst_indice", indice, 0);
      chk("rst_offset", offset, 0);
      chk("rst_erro", erro, 0);
      @(negedge clock);
      reset = 1'b1;
      extra_valid = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock);
         #1;
         if (valido || ocupado) extra_valid++;
      end
      chk("rst_no_valido", extra_valid, 0);
      run_decode(1'b0, 16'd1500, lat, busy, seen, idx, off, err, vafter);
      chk("post_rst_valid_seen", seen, 1);
      chk("post_rst_indice", idx, 3);
      chk("post_rst_offset", off, 0);
      chk("post_rst_erro", err, 0);

      // Round trip through the address-manager equation.
      for (int r = 0; r < 2; r++) begin
         rsel = (r == 1);
         div = rsel ? 100 : 500;
         rt_bad = 0;
         for (int n = 0; n < 1000; n++) begin
            e_idx = $urandom_range(0, 31);
            e_off = $urandom_range(0, div - 1);
            run_decode(rsel, 16'(e_idx * div + e_off), lat, busy, seen, idx, off, err, vafter);
            if (seen != 1 || idx != e_idx || off != e_off || err != 0) begin
               if (rt_bad < 5)
                  $display("FAIL roundtrip_r%0d idx=%0d off=%0d got idx=%0d off=%0d erro=%0d valid=%0d",
                           r, e_idx, e_off, idx, off, err, seen);
               rt_bad++;
            end
         end
         chk($sformatf("roundtrip_r%0d_bad", r), rt_bad, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decodificador_enderecos.md
Name: decodificador_enderecos

Overview:
Inverse of the address manager. Takes a physical 16-bit address from instruction memory or data memory and recovers the logical pair (process/program index, offset within block).
- Instruction space: physical = indice*TAM_BLOCO_INSTR + offset.
- Data space: physical = indice*TAM_BLOCO_DADOS + offset.
- Used by the fault/trace logic and the context-switch path to identify which process owns an address.
- Implemented as a 16-iteration restoring shift-subtract divider with a start/valid handshake.

Parameters:
TAM_BLOCO_INSTR, 500, instruction-memory block size per program/process (words)
TAM_BLOCO_DADOS, 100, data-memory block size per process (words)
MAX_INDICE, 31, largest legal index (5-bit index field)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
iniciar  input  1  start request; sampled only in OCIOSO
regiao  input  1  0 = instruction space (divisor TAM_BLOCO_INSTR), 1 = data space (divisor TAM_BLOCO_DADOS)
enderecoFisico  input  16  physical address to decode
ocupado  output  1  high while a decode is in progress (DIVIDINDO)
valido  output  1  one-cycle pulse: indice/offset/erro are valid
indice  output  5  recovered index
offset  output  16  recovered offset (remainder), always < selected divisor
erro  output  1  quotient exceeded MAX_INDICE

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low; reset=0 at a rising edge forces the reset values.
- Reset values: state OCIOSO; ocupado=0; valido=0; indice=0; offset=0; erro=0; internal quotient, remainder and counter = 0.
- Reset mid-operation: reset overrides everything. The decode is abandoned, no valido pulse is produced, and all outputs take their reset values.
- State OCIOSO:
  - On the edge where iniciar=1, latch enderecoFisico into the dividend register.
  - Latch the divisor: TAM_BLOCO_INSTR if regiao=0, else TAM_BLOCO_DADOS. It is zero-extended to 17 bits.
  - Clear remainder and quotient, load counter=15, go to DIVIDINDO.
  - Any later change on regiao or enderecoFisico has no effect on that decode.
- State DIVIDINDO (ocupado=1), one iteration per edge, 16 iterations total:
  - Per iteration: rem' = {rem[15:0], dividend[counter]}. If rem' >= divisor, then rem = rem' - divisor and q[counter] = 1; else rem = rem' and q[counter] = 0.
  - The remainder is held in 17 bits.
  - After the iteration with counter=0, go to PRONTO and register the outputs:
    - offset = rem[15:0]
    - erro = (q > MAX_INDICE)
    - indice = q[4:0] when erro=0, MAX_INDICE when erro=1 (saturate)
- State PRONTO: valido=1 and ocupado=0 for exactly one cycle, then unconditionally return to OCIOSO.
- Output hold: indice, offset and erro hold their values until the next decode completes or reset.
- Latency: iniciar sampled at edge N; valido is high in the cycle following edge N+16. The next request can be accepted at edge N+18.
- Back-to-back: iniciar is ignored (not queued) in DIVIDINDO and PRONTO. The requester must wait for ocupado=0 and valido=0.
- Arithmetic is exact integer division for all 16-bit inputs:
  - Quotient range 0..131 for divisor 500; 0..655 for divisor 100.
  - Quotient is kept in 16 bits internally. Only the 5-bit saturated value is output.
- Boundaries:
  - Address 0 gives indice 0, offset 0, erro 0.
  - Address = k*divisor - 1 gives indice k-1, offset divisor-1.
  - Address = k*divisor gives indice k, offset 0 (wrap of offset at a block boundary).
- Round trip: for any legal indice (<= MAX_INDICE) and offset < divisor, decoding the manager's output reproduces the inputs exactly.

Test Plan:
1. Instruction space, basic decode: reset, regiao=0, enderecoFisico=1234, pulse iniciar → exactly 16 cycles later valido=1 with indice=2, offset=234, erro=0. ocupado is high for those 16 cycles.
2. Data space, block boundary: regiao=1, decode 299 → indice 2, offset 99. Then decode 300 → indice 3, offset 0. Then decode 0 → indice 0, offset 0. All with erro=0.
3. Index overflow: regiao=1, enderecoFisico=65535 → erro=1, indice=31, offset=35 (65535 = 655*100+35). Also regiao=0, 16000 → quotient 32: erro=1, indice=31, offset=0.
4. Handshake: pulse iniciar (address 700, regiao=0), then re-pulse iniciar with 999 at cycles 3 and 17 → single result only: indice 1, offset 200. A new request accepted after valido decodes 999 → indice 1, offset 499.
5. Reset mid-operation: start a decode, drive reset=0 at iteration 8 → next cycle all outputs 0, ocupado=0, no valido. A subsequent decode of 1500 (regiao=0) → indice 3, offset 0.
6. Round trip: random indice 0..31 and offset < divisor, fed through the address manager and then this block → original indice/offset returned, erro=0, for 1000 iterations per regiao.
